event_code_encoder: RTL and testbench
=====================================

Name: event_code_encoder

Overview:
- Sequential 7-line to 3-bit encoder; inverse of the team's 3-to-8 line decoder.
- Detects rising edges on event lines d1..d7 and queues each in a pending mask.
- Emits one binary code {x,y,z} per pending event, highest index first, over a valid/ready handshake.
- Code 000 (line d0) is never emitted and means "no event"; a downstream decoder reproduces the one-hot line.

Parameters:
- CODE_W, 3, code width; fixed at 3 for this block.
- N_LINES, 7, number of event lines, 2**CODE_W-1; fixed at 7.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; synchronous, active-low
- d1..d7  input  1 each  event request lines (level); an event is a 0->1 transition
- x  output  1  code MSB
- y  output  1  code middle bit
- z  output  1  code LSB
- valid  output  1  {x,y,z} holds a code awaiting acceptance
- ready  input  1  consumer accepts the code when valid&&ready at a rising edge
- pending  output  7  queued events, bit i-1 = line di
- ovf  output  1  sticky: an event arrived on a line already pending

Behaviour:
- Reset (rst_n=0 at a rising edge): x=y=z=0, valid=0, pending=0, ovf=0, edge-history register=0, state=IDLE. Reset mid-handshake drops the presented code and all queued events.
- Edge detect: d_q <= {d7..d1} every cycle; rise = d & ~d_q. A line high at reset release registers an edge one cycle after release.
- Pending update each cycle: pending_next = (pending & ~clr_mask) | rise.
  - clr_mask is the one-hot of the accepted code on an accept cycle, otherwise 0.
  - Set wins over clear: a new edge on the line being accepted stays pending and does not raise ovf.
  - ovf <= ovf | |(rise & pending & ~clr_mask).
- FSM states IDLE and PRESENT:
  - IDLE: if pending!=0, load {x,y,z} = index of the highest set bit (d7=111 ... d1=001), set valid=1, go to PRESENT. Otherwise hold, with valid=0 and the code at 000.
  - PRESENT: hold {x,y,z} and valid stable while ready=0; new higher-priority arrivals do not pre-empt. When ready=1, clear that pending bit, set valid=0, set code=000, go to IDLE.
  - Throughput is one code per 2 cycles, with a mandatory IDLE bubble.
- Latency: an edge sampled at edge n sets pending at n. IDLE loads the code at n+1, so valid is high after edge n+1.
- Priority is evaluated only in IDLE, against the registered pending mask.
- All outputs are registered; no combinational path from d*/ready to the outputs.
- Bits beyond line 7 do not exist; there is no wrap-around. The code is always within 1..7 when valid=1.

Decomposition:
- Package event_code_pkg: state enum (IDLE, PRESENT), CODE_W, N_LINES, NO_EVENT=3'b000.
- Sub-module prio_enc7: purely combinational, 7-bit mask in, 3-bit index of the highest set bit plus an any flag out. Reused by the FSM and by the bench's reference model.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with d3=1 -> all outputs 0. After release, pending=0000100 at the next edge, and valid=1 with {x,y,z}=011 one edge later.
- Single pulse d5 with ready held 1 -> valid high for exactly 1 cycle with code 101, then pending=0, then valid=0, then idle.
- Simultaneous rising d2 and d6 with ready=1 -> codes 110 then 010, each preceded by a one-cycle bubble; pending goes 0100010 -> 0000010 -> 0.
- Backpressure: ready=0 for 5 cycles while code 011 is valid, with d7 rising mid-wait -> code stays 011 until accepted, then the next code is 111.
- Overflow and set-wins:
  - Second d4 edge while bit 3 is pending (no accept) -> ovf=1, sticky until reset.
  - d4 edge on the same cycle its code is accepted -> bit 3 stays pending and ovf stays 0.
- Reset mid-operation: rst_n=0 while valid=1 and pending=1010000 -> the next cycle shows valid=0, pending=0, ovf=0, and no stale code is emitted afterwards.

Source files
------------

// File: rtl/event_code_encoder_pkg.sv
// Shared types and constants for the 7-line event code encoder.
// Code 000 is reserved as "no event"; lines d1..d7 map to codes 001..111.
package event_code_pkg;

  localparam int CODE_W  = 3;
  localparam int N_LINES = 7;

  localparam logic [CODE_W-1:0] NO_EVENT = 3'b000;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  // One-hot pending-mask bit for a code; NO_EVENT maps to an empty mask.
  function automatic logic [N_LINES-1:0] code_to_mask(input logic [CODE_W-1:0] code);
    logic [N_LINES-1:0] mask;
    mask = '0;
    for (int i = 0; i < N_LINES; i++) begin
      mask[i] = (code == 3'(i + 1));
    end
    return mask;
  endfunction

endpackage

// File: rtl/event_code_encoder_if.sv
// Code output handshake. valid/ready: the producer holds {x,y,z} and valid
// stable until a rising edge sees valid && ready; that edge is the transfer.
interface event_code_encoder_if;

  logic x;
  logic y;
  logic z;
  logic valid;
  logic ready;

  modport master (
    output x,
    output y,
    output z,
    output valid,
    input  ready
  );

  modport slave (
    input  x,
    input  y,
    input  z,
    input  valid,
    output ready
  );

endinterface

// File: rtl/event_code_encoder_prio_enc7.sv
// Combinational priority encoder: code of the highest set bit of a 7-bit mask.
// Bit i of the mask is line d(i+1), so the result is always 1..7 when any=1.
module prio_enc7
  import event_code_pkg::*;
(
  input  logic [N_LINES-1:0] mask,
  output logic [CODE_W-1:0]  idx,
  output logic               any
);

  // Ascending scan: the last hit (highest line) wins.
  always_comb begin
    idx = NO_EVENT;
    for (int i = 0; i < N_LINES; i++) begin
      if (mask[i]) begin
        idx = 3'(i + 1);
      end
    end
  end

  assign any = |mask;

endmodule

// File: rtl/event_code_encoder.sv
// Queues rising edges on d1..d7 and emits one 3-bit code per event,
// highest line first, over a registered valid/ready handshake.
module event_code_encoder
  import event_code_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 d1,
  input  logic                 d2,
  input  logic                 d3,
  input  logic                 d4,
  input  logic                 d5,
  input  logic                 d6,
  input  logic                 d7,
  event_code_encoder_if.master code_bus,
  output logic [N_LINES-1:0]   pending,
  output logic                 ovf,
  output state_t               dbg_state
);

  logic [N_LINES-1:0] d;
  logic [N_LINES-1:0] d_q;
  logic [N_LINES-1:0] rise;
  logic [N_LINES-1:0] clr_mask;
  logic [N_LINES-1:0] pending_next;
  logic               accept;

  state_t             state;
  state_t             state_next;
  logic [CODE_W-1:0]  code;
  logic [CODE_W-1:0]  code_next;
  logic               valid_q;
  logic               valid_next;

  logic [CODE_W-1:0]  top_idx;
  logic               top_any;

  assign d        = {d7, d6, d5, d4, d3, d2, d1};
  assign rise     = d & ~d_q;
  assign accept   = (state == PRESENT) && code_bus.ready;
  assign clr_mask = accept ? code_to_mask(code) : '0;

  // OR-ing rise after the clear lets a fresh edge on the accepted line survive.
  assign pending_next = (pending & ~clr_mask) | rise;

  prio_enc7 u_prio (
    .mask (pending),
    .idx  (top_idx),
    .any  (top_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_q     <= '0;
      pending <= '0;
      ovf     <= 1'b0;
      state   <= IDLE;
      code    <= NO_EVENT;
      valid_q <= 1'b0;
    end else begin
      d_q     <= d;
      pending <= pending_next;
      ovf     <= ovf | (|(rise & pending & ~clr_mask));
      state   <= state_next;
      code    <= code_next;
      valid_q <= valid_next;
    end
  end

  // Priority is only taken in IDLE, so a presented code is never pre-empted.
  always_comb begin
    state_next = state;
    code_next  = code;
    valid_next = valid_q;
    case (state)
      IDLE: begin
        if (top_any) begin
          code_next  = top_idx;
          valid_next = 1'b1;
          state_next = PRESENT;
        end else begin
          code_next  = NO_EVENT;
          valid_next = 1'b0;
        end
      end
      PRESENT: begin
        if (code_bus.ready) begin
          code_next  = NO_EVENT;
          valid_next = 1'b0;
          state_next = IDLE;
        end
      end
    endcase
  end

  assign code_bus.x     = code[2];
  assign code_bus.y     = code[1];
  assign code_bus.z     = code[0];
  assign code_bus.valid = valid_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_event_code_encoder.sv
// Bench for event_code_encoder: directed scenarios then random traffic,
// scored against a line-array reference model and an expected-code queue.
module tb_event_code_encoder;
  import event_code_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:1]   d_vec = '0;
  logic [6:0]   pending;
  logic         ovf;
  state_t       dbg_state;

  event_code_encoder_if bus ();

  event_code_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .d1        (d_vec[1]),
    .d2        (d_vec[2]),
    .d3        (d_vec[3]),
    .d4        (d_vec[4]),
    .d5        (d_vec[5]),
    .d6        (d_vec[6]),
    .d7        (d_vec[7]),
    .code_bus  (bus),
    .pending   (pending),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_errors = 0;
  logic [2:0] exp_q[$];

  bit m_pend[1:7];
  bit m_dq[1:7];
  bit m_ovf;
  bit m_valid;
  int m_code;
  bit mon_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int code_now();
    return int'({bus.x, bus.y, bus.z});
  endfunction

  // ---------------- reference model ----------------
  // Per line: an event is input high now and low last cycle. The presented
  // code is the highest pending line chosen while nothing is presented.
  always @(posedge clk) begin : model
    bit acc;
    bit clr;
    bit r;
    bit nxt[1:7];
    int top;
    if (!rst_n) begin
      for (int i = 1; i <= 7; i++) begin
        m_pend[i] = 1'b0;
        m_dq[i]   = 1'b0;
      end
      m_ovf   = 1'b0;
      m_valid = 1'b0;
      m_code  = 0;
      exp_q.delete();
      mon_en  = 1'b1;
    end else begin
      acc = m_valid && bus.ready;
      for (int i = 1; i <= 7; i++) begin
        clr = acc && (m_code == i);
        r   = d_vec[i] && !m_dq[i];
        if (r && m_pend[i] && !clr) m_ovf = 1'b1;
        nxt[i] = (m_pend[i] && !clr) || r;
      end
      if (m_valid) begin
        if (bus.ready) begin
          m_valid = 1'b0;
          m_code  = 0;
        end
      end else begin
        top = 0;
        for (int i = 1; i <= 7; i++) if (m_pend[i]) top = i;
        if (top != 0) begin
          m_valid = 1'b1;
          m_code  = top;
          exp_q.push_back(3'(top));
        end
      end
      for (int i = 1; i <= 7; i++) begin
        m_pend[i] = nxt[i];
        m_dq[i]   = d_vec[i];
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    int pm;
    if (mon_en) begin
      pm = 0;
      for (int i = 1; i <= 7; i++) if (m_pend[i]) pm |= (1 << (i - 1));
      check("pending", int'(pending), pm);
      check("ovf", int'(ovf), int'(m_ovf));
      check("valid", int'(bus.valid), int'(m_valid));
      check("code", code_now(), m_code);
      check("state", int'(dbg_state == PRESENT), int'(m_valid));
      if (bus.valid) begin
        check("queue_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          check("order", code_now(), int'(exp_q[0]));
          if (bus.ready && rst_n) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.ready = 1'b0;

    // Reset with d3 held high, then its edge appears after release.
    rst_n    = 1'b0;
    d_vec[3] = 1'b1;
    repeat (2) step();
    check("rst_valid", int'(bus.valid), 0);
    check("rst_code", code_now(), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_ovf", int'(ovf), 0);
    rst_n = 1'b1;
    step();
    check("rel_pending", int'(pending), 7'b0000100);
    check("rel_valid_early", int'(bus.valid), 0);
    step();
    check("rel_valid", int'(bus.valid), 1);
    check("rel_code", code_now(), 3);
    d_vec     = '0;
    bus.ready = 1'b1;
    step();
    check("rel_acc_pending", int'(pending), 0);
    check("rel_acc_valid", int'(bus.valid), 0);
    repeat (3) step();

    // Single pulse on d5 with ready held high.
    d_vec[5] = 1'b1;
    step();
    d_vec[5] = 1'b0;
    check("d5_pending", int'(pending), 7'b0010000);
    step();
    check("d5_valid", int'(bus.valid), 1);
    check("d5_code", code_now(), 5);
    step();
    check("d5_done_valid", int'(bus.valid), 0);
    check("d5_done_pending", int'(pending), 0);
    step();
    check("d5_idle", int'(bus.valid), 0);

    // Simultaneous d2 and d6.
    d_vec = 7'b0100010;
    step();
    d_vec = '0;
    check("d26_pending", int'(pending), 7'b0100010);
    step();
    check("d26_first", code_now(), 6);
    step();
    check("d26_bubble", int'(bus.valid), 0);
    check("d26_pending2", int'(pending), 7'b0000010);
    step();
    check("d26_second", code_now(), 2);
    step();
    check("d26_pending3", int'(pending), 0);

    // Backpressure on code 3 with a d7 edge during the wait.
    bus.ready = 1'b0;
    d_vec[3]  = 1'b1;
    step();
    d_vec[3] = 1'b0;
    step();
    check("bp_valid", int'(bus.valid), 1);
    for (int i = 0; i < 5; i++) begin
      d_vec[7] = (i == 2);
      step();
      check("bp_hold", code_now(), 3);
    end
    d_vec[7]  = 1'b0;
    bus.ready = 1'b1;
    step();
    check("bp_pending", int'(pending), 7'b1000000);
    step();
    check("bp_next", code_now(), 7);
    step();
    check("bp_drained", int'(pending), 0);

    // Overflow: second d4 edge while d4 is still pending.
    bus.ready = 1'b0;
    d_vec[4]  = 1'b1;
    step();
    d_vec[4] = 1'b0;
    step();
    d_vec[4] = 1'b1;
    step();
    check("ovf_set", int'(ovf), 1);
    d_vec[4]  = 1'b0;
    bus.ready = 1'b1;
    repeat (4) step();
    check("ovf_sticky", int'(ovf), 1);

    // Set wins over clear on the accepted line.
    rst_n = 1'b0;
    step();
    check("ovf_cleared", int'(ovf), 0);
    rst_n     = 1'b1;
    bus.ready = 1'b0;
    d_vec[4]  = 1'b1;
    step();
    d_vec[4] = 1'b0;
    step();
    step();
    check("sw_code", code_now(), 4);
    bus.ready = 1'b1;
    d_vec[4]  = 1'b1;
    step();
    check("sw_pending", int'(pending), 7'b0001000);
    check("sw_ovf", int'(ovf), 0);
    d_vec[4] = 1'b0;
    step();
    check("sw_reload", code_now(), 4);
    step();
    check("sw_drained", int'(pending), 0);

    // Reset while a code is presented.
    bus.ready = 1'b0;
    d_vec     = 7'b1010000;
    step();
    d_vec = '0;
    check("mid_pending", int'(pending), 7'b1010000);
    step();
    check("mid_code", code_now(), 7);
    rst_n = 1'b0;
    step();
    check("mid_valid", int'(bus.valid), 0);
    check("mid_pend_clr", int'(pending), 0);
    check("mid_ovf", int'(ovf), 0);
    rst_n     = 1'b1;
    bus.ready = 1'b1;
    repeat (5) step();
    check("mid_no_stale", int'(bus.valid), 0);

    // Random traffic with one reset pulse in the middle.
    for (int c = 0; c < 400; c++) begin
      for (int l = 1; l <= 7; l++) begin
        if ($urandom_range(0, 99) < 15) d_vec[l] = ~d_vec[l];
      end
      bus.ready = ($urandom_range(0, 3) != 0);
      rst_n     = !(c == 200);
      step();
    end

    // Drain.
    rst_n     = 1'b1;
    d_vec     = '0;
    bus.ready = 1'b1;
    repeat (30) step();
    check("drain_queue", exp_q.size(), 0);
    check("drain_pending", int'(pending), 0);
    check("drain_valid", int'(bus.valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
